// File: rtl/vga_timing_pkg.sv
// Shared 640x480 @ 60 Hz raster constants and the coordinate width.
// Renderers and the sync generator both import these, so the screen
// size is defined in one place only.
package vga_timing_pkg;

    // Width of pixel_x / pixel_y on the pixel-coordinate interface.
    localparam int COORD_W = 11;

    localparam int VGA_H_DISPLAY = 640;
    localparam int VGA_H_FRONT   = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BACK    = 48;
    localparam int VGA_H_TOTAL   = VGA_H_DISPLAY + VGA_H_FRONT + VGA_H_SYNC + VGA_H_BACK;

    localparam int VGA_V_DISPLAY = 480;
    localparam int VGA_V_FRONT   = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BACK    = 33;
    localparam int VGA_V_TOTAL   = VGA_V_DISPLAY + VGA_V_FRONT + VGA_V_SYNC + VGA_V_BACK;

    // Inclusive range test on a coordinate.
    function automatic logic in_range(input logic [COORD_W-1:0] val,
                                      input logic [COORD_W-1:0] lo,
                                      input logic [COORD_W-1:0] hi);
        return (val >= lo) && (val <= hi);
    endfunction

endpackage

// File: rtl/pixel_tick_gen.sv
// Pixel-rate enable generator.
// Divides the board clock by CLK_DIV and produces a one-clock-wide
// enable once every CLK_DIV clocks.
// Ports:
//   clk_i     board clock
//   reset_i   asynchronous, active-high reset
//   p_tick_o  pixel enable, high when the divider sits at CLK_DIV-1
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk_i,
    input  logic reset_i,
    output logic p_tick_o
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] div_d;

    always_comb begin
        div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            div_q <= '0;
        end else begin
            div_q <= div_d;
        end
    end

    // Decoded straight from the divider so the first tick lands CLK_DIV-1
    // clocks after release. Gating with reset keeps the CLK_DIV=1 case
    // (divider permanently at its last value) low while in reset.
    assign p_tick_o = !reset_i && (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// Raster timing generator for 640x480 @ 60 Hz VGA.
// Drives the pixel-coordinate interface consumed by the renderers, the
// hsync/vsync pins and a once-per-frame strobe for game logic.
// Ports:
//   clk          board clock (100 MHz)
//   reset        asynchronous, active-high reset
//   p_tick       pixel enable, one clk wide every CLK_DIV clocks
//   pixel_x      horizontal position, 0..H_TOTAL-1
//   pixel_y      vertical position, 0..V_TOTAL-1
//   video_on     high inside the visible area
//   hsync        horizontal sync, active-low
//   vsync        vertical sync, active-low
//   frame_start  one-clk pulse when the raster wraps to (0,0)
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int H_DISPLAY = VGA_H_DISPLAY,
    parameter int H_FRONT   = VGA_H_FRONT,
    parameter int H_SYNC    = VGA_H_SYNC,
    parameter int H_BACK    = VGA_H_BACK,
    parameter int V_DISPLAY = VGA_V_DISPLAY,
    parameter int V_FRONT   = VGA_V_FRONT,
    parameter int V_SYNC    = VGA_V_SYNC,
    parameter int V_BACK    = VGA_V_BACK
) (
    input  logic               clk,
    input  logic               reset,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_start
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

    localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

    logic               tick;
    logic [COORD_W-1:0] h_q, h_d;
    logic [COORD_W-1:0] v_q, v_d;
    logic               hsync_q, hsync_d;
    logic               vsync_q, vsync_d;
    logic               video_on_q, video_on_d;
    logic               frame_start_q, frame_start_d;

    pixel_tick_gen #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk_i    (clk),
        .reset_i  (reset),
        .p_tick_o (tick)
    );

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (tick) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 1'b1;
            end else begin
                h_d = h_q + 1'b1;
            end
        end

        // Decoding the next position keeps the registered sync/blank
        // signals aligned with the registered coordinates they describe.
        hsync_d    = !in_range(h_d, HS_FIRST, HS_LAST);
        vsync_d    = !in_range(v_d, VS_FIRST, VS_LAST);
        video_on_d = (h_d < H_VIS) && (v_d < V_VIS);

        // Only a natural wrap from the last pixel counts; the restart
        // after reset deliberately produces no strobe.
        frame_start_d = tick && (h_q == H_LAST) && (v_q == V_LAST);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_q           <= '0;
            v_q           <= '0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            video_on_q    <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            h_q           <= h_d;
            v_q           <= v_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            video_on_q    <= video_on_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign p_tick      = tick;
    assign pixel_x     = h_q;
    assign pixel_y     = v_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign video_on    = video_on_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_sync_gen.sv
module tb_vga_sync_gen;

    typedef struct packed {
        logic        p_tick;
        logic [10:0] x;
        logic [10:0] y;
        logic        von;
        logic        hs;
        logic        vs;
        logic        fs;
    } obs_t;

    logic clk;
    logic reset;

    // Three instances: default timing, a shrunken raster with CLK_DIV=3,
    // and the same shrunken raster with CLK_DIV=1.
    logic        d_tick, d_von, d_hs, d_vs, d_fs;
    logic [10:0] d_x, d_y;
    logic        s_tick, s_von, s_hs, s_vs, s_fs;
    logic [10:0] s_x, s_y;
    logic        o_tick, o_von, o_hs, o_vs, o_fs;
    logic [10:0] o_x, o_y;

    vga_sync_gen u_def (
        .clk(clk), .reset(reset), .p_tick(d_tick), .pixel_x(d_x), .pixel_y(d_y),
        .video_on(d_von), .hsync(d_hs), .vsync(d_vs), .frame_start(d_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(3), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_small (
        .clk(clk), .reset(reset), .p_tick(s_tick), .pixel_x(s_x), .pixel_y(s_y),
        .video_on(s_von), .hsync(s_hs), .vsync(s_vs), .frame_start(s_fs)
    );

    vga_sync_gen #(
        .CLK_DIV(1), .H_DISPLAY(20), .H_FRONT(3), .H_SYNC(4), .H_BACK(5),
        .V_DISPLAY(10), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_div1 (
        .clk(clk), .reset(reset), .p_tick(o_tick), .pixel_x(o_x), .pixel_y(o_y),
        .video_on(o_von), .hsync(o_hs), .vsync(o_vs), .frame_start(o_fs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    obs_t q_def[$];
    obs_t q_small[$];
    obs_t q_div1[$];

    // Reference: after release the raster position is simply the number of
    // pixel periods elapsed. k = clock edges since release.
    function automatic obs_t model(input bit in_rst, input int unsigned k, input int d,
                                   input int hd, input int hf, input int hs, input int hb,
                                   input int vd, input int vf, input int vs, input int vb);
        obs_t e;
        int unsigned ht, vt, p, x, y;
        e.p_tick = 1'b0;
        e.x      = '0;
        e.y      = '0;
        e.von    = 1'b0;
        e.hs     = 1'b1;
        e.vs     = 1'b1;
        e.fs     = 1'b0;
        if (in_rst) return e;
        e.p_tick = ((k % d) == (d - 1));
        if (k == 0) return e;
        ht = hd + hf + hs + hb;
        vt = vd + vf + vs + vb;
        p  = k / d;
        x  = p % ht;
        y  = (p / ht) % vt;
        e.x   = 11'(x);
        e.y   = 11'(y);
        e.von = (x < hd) && (y < vd);
        e.hs  = !((x >= hd + hf) && (x < hd + hf + hs));
        e.vs  = !((y >= vd + vf) && (y < vd + vf + vs));
        e.fs  = ((k % d) == 0) && (p % (ht * vt) == 0);
        return e;
    endfunction

    task automatic push_all(input bit in_rst, input int unsigned k);
        q_def.push_back(model(in_rst, k, 4, 640, 16, 96, 48, 480, 10, 2, 33));
        q_small.push_back(model(in_rst, k, 3, 20, 3, 4, 5, 10, 2, 2, 3));
        q_div1.push_back(model(in_rst, k, 1, 20, 3, 4, 5, 10, 2, 2, 3));
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%0d expected=%0d", name, $time, act, req);
        end
    endtask

    task automatic cmp(input string tag, input obs_t e, input obs_t a);
        chk({tag, ".p_tick"},      int'(a.p_tick), int'(e.p_tick));
        chk({tag, ".pixel_x"},     int'(a.x),      int'(e.x));
        chk({tag, ".pixel_y"},     int'(a.y),      int'(e.y));
        chk({tag, ".video_on"},    int'(a.von),    int'(e.von));
        chk({tag, ".hsync"},       int'(a.hs),     int'(e.hs));
        chk({tag, ".vsync"},       int'(a.vs),     int'(e.vs));
        chk({tag, ".frame_start"}, int'(a.fs),     int'(e.fs));
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        obs_t e, a;
        if (q_def.size() != 0) begin
            e = q_def.pop_front();
            a = '{d_tick, d_x, d_y, d_von, d_hs, d_vs, d_fs};
            cmp("def", e, a);
        end
        if (q_small.size() != 0) begin
            e = q_small.pop_front();
            a = '{s_tick, s_x, s_y, s_von, s_hs, s_vs, s_fs};
            cmp("small", e, a);
        end
        if (q_div1.size() != 0) begin
            e = q_div1.pop_front();
            a = '{o_tick, o_x, o_y, o_von, o_hs, o_vs, o_fs};
            cmp("div1", e, a);
        end
    end

    // Stimulus: random run lengths between asynchronous reset pulses that
    // land mid-cycle. The first run covers two full default lines and
    // several complete frames of the shrunken rasters.
    initial begin
        int unsigned k;
        int unsigned len;
        int unsigned hold;
        reset = 1'b1;
        k     = 0;
        repeat (3) begin
            @(posedge clk);
            #2;
            push_all(1'b1, 0);
        end
        for (int seg = 0; seg < 7; seg++) begin
            len = (seg == 0) ? 7000 : $urandom_range(50, 3000);
            @(posedge clk);
            #2;
            reset = 1'b0;
            k     = 0;
            push_all(1'b0, 0);
            repeat (len) begin
                @(posedge clk);
                k++;
                #2;
                push_all(1'b0, k);
            end
            @(posedge clk);
            #($urandom_range(1, 4));
            reset = 1'b1;
            push_all(1'b1, 0);
            hold = $urandom_range(1, 4);
            repeat (hold) begin
                @(posedge clk);
                #2;
                push_all(1'b1, 0);
            end
        end
        @(negedge clk);
        @(negedge clk);
        chk("scoreboard_drained", q_def.size() + q_small.size() + q_div1.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
